fetch_unit: RTL and testbench

- Parametrised instruction-fetch / program-counter unit, next generation of the basic PC block.
- Adds an explicit run/halt state machine with a Start handshake, plus a stall input.
- Adds absolute or PC-relative conditional branches and a bounded return-address stack (RAS) for call/return.
- Drives PC to instruction memory and Halt/Running to the testbench and top level.

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - control and status bundle between a sequencer and the fetch unit
interface fetch_unit_if #(
    parameter int PW = 10
);
    logic          Start;
    logic          Stall;
    logic          Branch_en;
    logic          FLAG_IN;
    logic          Br_rel;
    logic [PW-1:0] Target;
    logic          Call_en;
    logic          Ret_en;
    logic [PW-1:0] PC;
    logic          Halt;
    logic          Running;
    logic          Stack_err;

    modport master (
        output Start, Stall, Branch_en, FLAG_IN, Br_rel, Target, Call_en, Ret_en,
        input  PC, Halt, Running, Stack_err
    );

    modport slave (
        input  Start, Stall, Branch_en, FLAG_IN, Br_rel, Target, Call_en, Ret_en,
        output PC, Halt, Running, Stack_err
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter with run/halt control, branches and return-address stack
module fetch_unit #(
    parameter int PW         = 10,
    parameter int START_ADDR = 0,
    parameter int HALT_ADDR  = 258,
    parameter int RAS_DEPTH  = 4
) (
    input  logic         CLK,
    input  logic         Init,
    fetch_unit_if.slave  bus
);
    localparam int            PTR_W    = $clog2(RAS_DEPTH);
    localparam int            CNT_W    = PTR_W + 1;
    localparam logic [PW-1:0] START_PC = PW'(START_ADDR);
    localparam logic [PW-1:0] HALT_PC  = PW'(HALT_ADDR);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    pc_q, pc_d;
    logic             halt_q, halt_d;
    logic             running_q, running_d;
    logic             err_q, err_d;
    logic [PW-1:0]    ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             push, pop, clear;
    logic [PW-1:0]    pc_inc;
    logic [PTR_W-1:0] top_idx;

    // ptr_q points at the next free slot; the newest entry sits one below it.
    // Pushing when full lands on the oldest entry, giving circular overwrite for free.
    assign pc_inc  = pc_q + PW'(1);
    assign top_idx = ptr_q - PTR_W'(1);

    // Next-state decision: priority stall > return > call > branch > halt > increment.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        halt_d  = halt_q;
        err_d   = err_q;
        push    = 1'b0;
        pop     = 1'b0;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                pc_d = START_PC;
                if (bus.Start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.Stall) begin
                    if (bus.Ret_en) begin
                        if (cnt_q != '0) begin
                            pc_d = ras_q[top_idx];
                            pop  = 1'b1;
                        end else begin
                            pc_d  = pc_inc;
                            err_d = 1'b1;
                        end
                    end else if (bus.Call_en) begin
                        push = 1'b1;
                        pc_d = bus.Target;
                        if (cnt_q == FULL_CNT) begin
                            err_d = 1'b1;
                        end
                    end else if (bus.Branch_en && bus.FLAG_IN) begin
                        pc_d = bus.Br_rel ? (pc_q + bus.Target) : bus.Target;
                    end else if (pc_q == HALT_PC) begin
                        pc_d    = pc_inc;
                        halt_d  = 1'b1;
                        state_d = HALTED;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            HALTED: begin
                if (bus.Start) begin
                    pc_d    = START_PC;
                    halt_d  = 1'b0;
                    clear   = 1'b1;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = START_PC;
            end
        endcase
        running_d = (state_d == RUN);
    end

    // Stack pointer and occupancy bookkeeping; occupancy saturates at full.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (clear) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (push) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (cnt_q != FULL_CNT) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // All architectural state, including the stack storage, with async reset to IDLE.
    always_ff @(posedge CLK or negedge Init) begin
        if (!Init) begin
            state_q   <= IDLE;
            pc_q      <= START_PC;
            halt_q    <= 1'b0;
            running_q <= 1'b0;
            err_q     <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            halt_q    <= halt_d;
            running_q <= running_d;
            err_q     <= err_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            if (push) begin
                ras_q[ptr_q] <= pc_inc;
            end
        end
    end

    assign bus.PC        = pc_q;
    assign bus.Halt      = halt_q;
    assign bus.Running   = running_q;
    assign bus.Stack_err = err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit
module tb_fetch_unit;
    logic clk;
    logic init;
    int   checks;
    int   failures;

    fetch_unit_if #(.PW(10)) bus ();

    fetch_unit #(
        .PW(10), .START_ADDR(0), .HALT_ADDR(258), .RAS_DEPTH(4)
    ) dut (
        .CLK (clk),
        .Init(init),
        .bus (bus.slave)
    );

    typedef struct {
        logic       stall;
        logic       br;
        logic       flag;
        logic       rel;
        logic       call;
        logic       ret;
        logic [9:0] target;
        int         exp_pc;
        logic       exp_halt;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic stall, input logic br, input logic flag,
                                input logic rel, input logic call, input logic ret,
                                input int target, input int exp_pc,
                                input logic exp_halt, input logic exp_err);
        vec_t v;
        v.stall = stall; v.br = br; v.flag = flag; v.rel = rel;
        v.call = call; v.ret = ret; v.target = 10'(target);
        v.exp_pc = exp_pc; v.exp_halt = exp_halt; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.Start = 0; bus.Stall = 0; bus.Branch_en = 0; bus.FLAG_IN = 0;
        bus.Br_rel = 0; bus.Target = '0; bus.Call_en = 0; bus.Ret_en = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        init = 1'b0;
        tick();
        tick();
        init = 1'b1;
        tick();
    endtask

    task automatic do_start();
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
    endtask

    task automatic check_state(input string tag, input int pc, input int halt,
                               input int run, input int err);
        check({tag, "_pc"},   int'(bus.PC),        pc);
        check({tag, "_halt"}, int'(bus.Halt),      halt);
        check({tag, "_run"},  int'(bus.Running),   run);
        check({tag, "_err"},  int'(bus.Stack_err), err);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        init     = 1'b1;

        // Reset and IDLE hold, even with noise on the control inputs.
        do_reset();
        check_state("reset", 0, 0, 0, 0);
        bus.Stall = 1; bus.Branch_en = 1; bus.FLAG_IN = 1; bus.Target = 10'd77;
        tick();
        check_state("idle_hold", 0, 0, 0, 0);
        clear_inputs();

        // Straight-line run to the halt address; Start mid-run is ignored.
        do_start();
        check_state("start", 0, 0, 1, 0);
        for (int i = 1; i <= 258; i++) begin
            bus.Start = (i == 101);
            tick();
            check("run_pc", int'(bus.PC), i);
            check("run_halt", int'(bus.Halt), 0);
        end
        bus.Start = 0;
        tick();
        check_state("halted", 259, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            bus.Stall = 1'($urandom_range(1)); bus.Branch_en = 1; bus.FLAG_IN = 1;
            bus.Target = 10'd5; bus.Call_en = 1'($urandom_range(1));
            bus.Ret_en = 1'($urandom_range(1));
            tick();
            check("halt_hold_pc", int'(bus.PC), 259);
            check("halt_hold_halt", int'(bus.Halt), 1);
        end
        clear_inputs();

        // Branch, call/return, stall, wrap and halt-override vectors.
        do_reset();
        do_start();
        for (int i = 1; i <= 5; i++) vecs.push_back(mk(0,0,0,0,0,0,0,i,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,40,6,0,0));
        vecs.push_back(mk(0,1,1,0,0,0,40,40,0,0));
        vecs.push_back(mk(0,1,1,1,0,0,10'h3FD,37,0,0));
        vecs.push_back(mk(0,1,1,0,0,0,10,10,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,100,100,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,200,200,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,0,101,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,0,11,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,0,12,0,1));
        vecs.push_back(mk(0,0,0,0,1,1,300,13,0,1));
        vecs.push_back(mk(0,1,1,0,0,0,20,20,0,1));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1,1,1,0,0,0,300,20,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,0,21,0,1));
        vecs.push_back(mk(0,1,1,0,0,0,20,20,0,1));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1,1,1,0,0,0,50,20,0,1));
        vecs.push_back(mk(0,1,1,0,0,0,50,50,0,1));
        vecs.push_back(mk(1,0,0,0,1,0,7,50,0,1));
        vecs.push_back(mk(0,0,0,0,0,1,0,51,0,1));
        vecs.push_back(mk(0,1,1,1,0,0,10'h3FF,50,0,1));
        vecs.push_back(mk(0,1,1,0,0,0,1023,1023,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1));
        vecs.push_back(mk(0,1,1,0,0,0,258,258,0,1));
        vecs.push_back(mk(0,1,1,0,0,0,258,258,0,1));
        vecs.push_back(mk(0,0,0,0,1,0,5,5,0,1));
        vecs.push_back(mk(0,0,0,0,0,1,0,259,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,0,260,0,1));
        vecs.push_back(mk(0,0,0,0,1,0,250,250,0,1));
        foreach (vecs[i]) begin
            bus.Stall = vecs[i].stall; bus.Branch_en = vecs[i].br;
            bus.FLAG_IN = vecs[i].flag; bus.Br_rel = vecs[i].rel;
            bus.Call_en = vecs[i].call; bus.Ret_en = vecs[i].ret;
            bus.Target = vecs[i].target;
            tick();
            check($sformatf("vec%0d_pc", i), int'(bus.PC), vecs[i].exp_pc);
            check($sformatf("vec%0d_halt", i), int'(bus.Halt), int'(vecs[i].exp_halt));
            check($sformatf("vec%0d_err", i), int'(bus.Stack_err), int'(vecs[i].exp_err));
            check($sformatf("vec%0d_run", i), int'(bus.Running), 1);
        end
        clear_inputs();

        // Run from 250 into HALTED, then restart: Stack_err kept, RAS emptied.
        begin
            int n;
            n = 0;
            while (!bus.Halt && n < 20) begin
                tick();
                n++;
            end
            check("halt_reached_cycles", n, 9);
        end
        check_state("halted2", 259, 1, 0, 1);
        do_start();
        check_state("restart", 0, 0, 1, 1);
        bus.Ret_en = 1;
        tick();
        bus.Ret_en = 0;
        check_state("restart_ras_empty", 1, 0, 1, 1);
        tick();
        tick();
        check("pre_async_pc", int'(bus.PC), 3);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #3;
        init = 1'b0;
        #1;
        check_state("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        init = 1'b1;
        tick();
        check_state("post_rst_idle", 0, 0, 0, 0);

        // Nested calls overflow a 4-deep stack; returns pop newest first.
        do_start();
        for (int k = 0; k < 5; k++) begin
            bus.Call_en = 1;
            bus.Target = 10'((k + 1) * 100);
            tick();
            check("nest_call_pc", int'(bus.PC), (k + 1) * 100);
            check("nest_call_err", int'(bus.Stack_err), (k == 4) ? 1 : 0);
        end
        bus.Call_en = 0;
        for (int k = 0; k < 5; k++) begin
            bus.Ret_en = 1;
            tick();
            check("nest_ret_pc", int'(bus.PC), (k < 4) ? (401 - 100 * k) : 102);
            check("nest_ret_err", int'(bus.Stack_err), 1);
        end
        clear_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
